// File: rtl/bcd_adjust_pkg.sv
// Shared constants for the bcd_adjust decimal-correction stage.
// State encoding and the BCD nibble correction constant.
package bcd_adjust_pkg;

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StAdj  = 1'b1;

   localparam logic [3:0] BCD_FIX = 4'h6;

endpackage

// File: rtl/bcd_nibble_fix.sv
// Single-nibble decimal correction: adds or subtracts 6 (mod 16) when enabled.
module bcd_nibble_fix
   import bcd_adjust_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       en_i,
   input  logic       sub_i,
   output logic [3:0] nib_o
);

   always_comb begin
      nib_o = nib_i;
      if (en_i) begin
         nib_o = sub_i ? (nib_i - BCD_FIX) : (nib_i + BCD_FIX);
      end
   end

endmodule

// File: rtl/bcd_adjust.sv
// Decimal-correction stage after the ALU; produces final A value and C/V/N/Z.
// Define BCD_ADJUST_EXTRA_CYCLE_EN for the 65C02 extra decimal cycle (N/Z from corrected value).
module bcd_adjust
   import bcd_adjust_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       RDY,
   input  logic       start,
   input  logic       sub,
   input  logic       bcd,
   input  logic [7:0] alu_out,
   input  logic       alu_co,
   input  logic       alu_hc,
   input  logic       alu_v,
   output logic [7:0] out,
   output logic       co,
   output logic       v,
   output logic       n,
   output logic       z,
   output logic       valid,
   output logic       busy
);

   logic [7:0] fix_src;
   logic [7:0] fixed;
   logic       fix_sub;
   logic       fix_hc;
   logic       fix_co;
   logic       lo_en;
   logic       hi_en;

   logic [7:0] out_q, out_d;
   logic       co_q, co_d;
   logic       v_q, v_d;
   logic       n_q, n_d;
   logic       z_q, z_d;
   logic       valid_q, valid_d;

`ifdef BCD_ADJUST_EXTRA_CYCLE_EN
   logic [0:0] state_q, state_d;
   logic [7:0] cap_out_q, cap_out_d;
   logic       cap_sub_q, cap_sub_d;
   logic       cap_hc_q, cap_hc_d;
   logic       cap_co_q, cap_co_d;
   logic       cap_v_q, cap_v_d;

   assign fix_src = cap_out_q;
   assign fix_sub = cap_sub_q;
   assign fix_hc  = cap_hc_q;
   assign fix_co  = cap_co_q;
   assign busy    = (state_q == StAdj);
`else
   assign fix_src = alu_out;
   assign fix_sub = sub;
   assign fix_hc  = alu_hc;
   assign fix_co  = alu_co;
   assign busy    = 1'b0;
`endif

   // ADC corrects on carry out of a nibble, SBC on the absence of borrow-free carry.
   assign lo_en = fix_sub ? ~fix_hc : fix_hc;
   assign hi_en = fix_sub ? ~fix_co : fix_co;

   bcd_nibble_fix u_fix_lo (
      .nib_i (fix_src[3:0]),
      .en_i  (lo_en),
      .sub_i (fix_sub),
      .nib_o (fixed[3:0])
   );

   bcd_nibble_fix u_fix_hi (
      .nib_i (fix_src[7:4]),
      .en_i  (hi_en),
      .sub_i (fix_sub),
      .nib_o (fixed[7:4])
   );

   always_comb begin
      out_d   = out_q;
      co_d    = co_q;
      v_d     = v_q;
      n_d     = n_q;
      z_d     = z_q;
      valid_d = valid_q;
`ifdef BCD_ADJUST_EXTRA_CYCLE_EN
      state_d   = state_q;
      cap_out_d = cap_out_q;
      cap_sub_d = cap_sub_q;
      cap_hc_d  = cap_hc_q;
      cap_co_d  = cap_co_q;
      cap_v_d   = cap_v_q;
`endif
      if (RDY) begin
         valid_d = 1'b0;
`ifdef BCD_ADJUST_EXTRA_CYCLE_EN
         case (state_q)
            StIdle: begin
               if (start) begin
                  cap_out_d = alu_out;
                  cap_sub_d = sub;
                  cap_hc_d  = alu_hc;
                  cap_co_d  = alu_co;
                  cap_v_d   = alu_v;
                  if (bcd) begin
                     state_d = StAdj;
                  end else begin
                     out_d   = alu_out;
                     co_d    = alu_co;
                     v_d     = alu_v;
                     n_d     = alu_out[7];
                     z_d     = (alu_out == 8'h00);
                     valid_d = 1'b1;
                  end
               end
            end
            StAdj: begin
               out_d   = fixed;
               co_d    = cap_co_q;
               v_d     = cap_v_q;
               n_d     = fixed[7];
               z_d     = (fixed == 8'h00);
               valid_d = 1'b1;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
`else
         if (start) begin
            // N/Z deliberately follow the uncorrected ALU value (NMOS behaviour).
            out_d   = bcd ? fixed : alu_out;
            co_d    = alu_co;
            v_d     = alu_v;
            n_d     = alu_out[7];
            z_d     = (alu_out == 8'h00);
            valid_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q   <= 8'h00;
         co_q    <= 1'b0;
         v_q     <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         valid_q <= 1'b0;
`ifdef BCD_ADJUST_EXTRA_CYCLE_EN
         state_q   <= StIdle;
         cap_out_q <= 8'h00;
         cap_sub_q <= 1'b0;
         cap_hc_q  <= 1'b0;
         cap_co_q  <= 1'b0;
         cap_v_q   <= 1'b0;
`endif
      end else begin
         out_q   <= out_d;
         co_q    <= co_d;
         v_q     <= v_d;
         n_q     <= n_d;
         z_q     <= z_d;
         valid_q <= valid_d;
`ifdef BCD_ADJUST_EXTRA_CYCLE_EN
         state_q   <= state_d;
         cap_out_q <= cap_out_d;
         cap_sub_q <= cap_sub_d;
         cap_hc_q  <= cap_hc_d;
         cap_co_q  <= cap_co_d;
         cap_v_q   <= cap_v_d;
`endif
      end
   end

   assign out   = out_q;
   assign co    = co_q;
   assign v     = v_q;
   assign n     = n_q;
   assign z     = z_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_bcd_adjust.sv
// Bench for bcd_adjust: cycle-level reference model plus hand-computed pinned results.
// Follows BCD_ADJUST_EXTRA_CYCLE_EN the same way the design does.
module tb_bcd_adjust;

`ifdef BCD_ADJUST_EXTRA_CYCLE_EN
   localparam bit Extra = 1'b1;
`else
   localparam bit Extra = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] o;
      logic       c;
      logic       v;
      logic       n;
      logic       z;
   } res_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       RDY;
   logic       start;
   logic       sub;
   logic       bcd;
   logic [7:0] alu_out;
   logic       alu_co;
   logic       alu_hc;
   logic       alu_v;
   logic [7:0] out;
   logic       co;
   logic       v;
   logic       n;
   logic       z;
   logic       valid;
   logic       busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   // Pinned literal expectations handed from the stimulus to the compare process.
   int          pin_id   = 0;
   int          pin_seen = 0;
   string       pin_name;
   logic [13:0] pin_exp;
   bit          pin_full;

   // Reference model state.
   res_t m_res;
   logic m_valid;
   res_t pend_r;
   logic pend_v;

   always #5 clk = ~clk;

   bcd_adjust dut (
      .clk     (clk),
      .reset   (reset),
      .RDY     (RDY),
      .start   (start),
      .sub     (sub),
      .bcd     (bcd),
      .alu_out (alu_out),
      .alu_co  (alu_co),
      .alu_hc  (alu_hc),
      .alu_v   (alu_v),
      .out     (out),
      .co      (co),
      .v       (v),
      .n       (n),
      .z       (z),
      .valid   (valid),
      .busy    (busy)
   );

   function automatic res_t calc(input logic s, input logic d, input logic [7:0] a,
                                 input logic c, input logic h, input logic ov);
      int   lo;
      int   hi;
      res_t r;
      lo = int'(a[3:0]);
      hi = int'(a[7:4]);
      if (d) begin
         if (!s && h)  lo = (lo + 6) % 16;
         if (s && !h)  lo = (lo + 10) % 16;
         if (!s && c)  hi = (hi + 6) % 16;
         if (s && !c)  hi = (hi + 10) % 16;
      end
      r.o = 8'(hi * 16 + lo);
      r.c = c;
      r.v = ov;
      if (Extra) begin
         r.n = r.o[7];
         r.z = (r.o == 8'h00);
      end else begin
         r.n = a[7];
         r.z = (a == 8'h00);
      end
      return r;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         m_res   <= '0;
         m_valid <= 1'b0;
         pend_v  <= 1'b0;
         pend_r  <= '0;
      end else if (RDY) begin
         if (pend_v) begin
            m_res   <= pend_r;
            m_valid <= 1'b1;
            pend_v  <= 1'b0;
         end else if (start) begin
            if (bcd && Extra) begin
               pend_r  <= calc(sub, bcd, alu_out, alu_co, alu_hc, alu_v);
               pend_v  <= 1'b1;
               m_valid <= 1'b0;
            end else begin
               m_res   <= calc(sub, bcd, alu_out, alu_co, alu_hc, alu_v);
               m_valid <= 1'b1;
            end
         end else begin
            m_valid <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      logic [13:0] act;
      logic [13:0] exp_v;
      act   = {valid, busy, out, co, v, n, z};
      exp_v = {m_valid, pend_v, m_res};
      if (chk_en) begin
         tests++;
         if (act !== exp_v) begin
            fails++;
            $display("FAIL model cyc=%0d got {valid,busy,out,c,v,n,z}=%b,%b,%h,%b%b%b%b want %b,%b,%h,%b%b%b%b",
                     cyc, act[13], act[12], act[11:4], act[3], act[2], act[1], act[0],
                     exp_v[13], exp_v[12], exp_v[11:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
         end
      end
      if (pin_id != pin_seen) begin
         pin_seen = pin_id;
         tests++;
         if (pin_full ? (act !== pin_exp) : (act[13:12] !== pin_exp[13:12])) begin
            fails++;
            $display("FAIL %s cyc=%0d got {valid,busy,out,c,v,n,z}=%b,%b,%h,%b%b%b%b want %b,%b,%h,%b%b%b%b",
                     pin_name, cyc, act[13], act[12], act[11:4], act[3], act[2], act[1], act[0],
                     pin_exp[13], pin_exp[12], pin_exp[11:4], pin_exp[3], pin_exp[2],
                     pin_exp[1], pin_exp[0]);
         end
      end
   end

   task automatic pin(input string nm, input logic [13:0] e, input bit full);
      pin_name = nm;
      pin_exp  = e;
      pin_full = full;
      pin_id++;
   endtask

   // Issue one start; returns #1 after the cycle in which the result is visible.
   task automatic op(input logic s, input logic d, input logic [7:0] a,
                     input logic c, input logic h, input logic ov);
      @(posedge clk);
      #1;
      sub = s; bcd = d; alu_out = a; alu_co = c; alu_hc = h; alu_v = ov;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
`ifdef BCD_ADJUST_EXTRA_CYCLE_EN
      if (d) begin
         pin("busy_T1", {1'b0, 1'b1, 12'h000}, 1'b0);
         @(posedge clk);
         #1;
      end
`endif
   endtask

   initial begin
      reset = 1'b1; RDY = 1'b1; start = 1'b0; sub = 1'b0; bcd = 1'b0;
      alu_out = 8'h00; alu_co = 1'b0; alu_hc = 1'b0; alu_v = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      pin("reset_state", 14'h0000, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      op(1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);
      pin("bin_80", {1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0}, 1'b1);

      op(1'b0, 1'b1, 8'h1A, 1'b0, 1'b1, 1'b0);
      pin("adc_09_01", {1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);

      // 99+01: ALU yields AA with both decimal carries set.
      op(1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
`ifdef BCD_ADJUST_EXTRA_CYCLE_EN
      pin("adc_99_01", {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1}, 1'b1);
`else
      pin("adc_99_01", {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}, 1'b1);
`endif

      op(1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
      pin("sbc_10_01", {1'b1, 1'b0, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b1);

      op(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      pin("sbc_00_01", {1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b1);

      op(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      pin("bin_zero", {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b1);

      // Back-to-back binary starts.
      @(posedge clk);
      #1;
      sub = 1'b0; bcd = 1'b0; alu_co = 1'b0; alu_hc = 1'b0; alu_v = 1'b0;
      alu_out = 8'h11; start = 1'b1;
      @(posedge clk);
      #1;
      alu_out = 8'h22;
      pin("b2b_11", {1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
      @(posedge clk);
      #1;
      alu_out = 8'h33;
      pin("b2b_22", {1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
      @(posedge clk);
      #1;
      start = 1'b0;
      pin("b2b_33", {1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);

      // RDY dropped for three cycles right after a decimal start.
      @(posedge clk);
      #1;
      bcd = 1'b1; sub = 1'b0; alu_out = 8'h1A; alu_hc = 1'b1; alu_co = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      RDY = 1'b0; bcd = 1'b0; alu_out = 8'h55;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      start = 1'b0;
`ifdef BCD_ADJUST_EXTRA_CYCLE_EN
      pin("rdy_hold", {1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
`else
      pin("rdy_hold", {1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
`endif
      @(posedge clk);
      #1;
      RDY = 1'b1;
      @(posedge clk);
      #1;
`ifdef BCD_ADJUST_EXTRA_CYCLE_EN
      pin("rdy_resume", {1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
`else
      pin("rdy_resume", {1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
`endif

      // RDY low with start high in IDLE: the start is lost.
      @(posedge clk);
      #1;
      RDY = 1'b0; start = 1'b1; bcd = 1'b0; alu_out = 8'h66;
      @(posedge clk);
      #1;
      RDY = 1'b1; start = 1'b0;

      // Reset asserted while a decimal result is pending.
      @(posedge clk);
      #1;
      bcd = 1'b1; sub = 1'b1; alu_out = 8'h0F; alu_hc = 1'b0; alu_co = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      pin("reset_adj", 14'h0000, 1'b1);
      @(posedge clk);
      #1;
      pin("reset_no_valid", 14'h0000, 1'b1);
      op(1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
      pin("post_reset_bin", {1'b1, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b1);

      // Extra vectors checked against the model only.
      op(1'b0, 1'b1, 8'hA0, 1'b1, 1'b1, 1'b1);
      op(1'b1, 1'b1, 8'h45, 1'b0, 1'b1, 1'b0);
      op(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
      op(1'b1, 1'b0, 8'hE4, 1'b1, 1'b0, 1'b1);
      op(1'b1, 1'b1, 8'hFA, 1'b0, 1'b0, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
